// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared state and datapath select codes for the multicycle control unit
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        JLINK    = 4'd12
    } state_t;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_XOR = 3'b100;
    localparam logic [2:0] ULA_SLT = 3'b101;
    localparam logic [2:0] ULA_SRL = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_ula.sv
// rtl/multicycle_control_ula.sv - ula_decoder: Funct3/Funct7 to ULAControl and instruction legality
module ula_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] ulacontrol,
    output logic       legal
);

    always_comb begin
        ulacontrol = ULA_ADD;
        legal      = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            ulacontrol = ULA_SUB;
                            legal      = 1'b1;
                        end
                    end
                    3'b111: begin ulacontrol = ULA_AND; legal = 1'b1; end
                    3'b110: begin ulacontrol = ULA_OR;  legal = 1'b1; end
                    3'b100: begin ulacontrol = ULA_XOR; legal = 1'b1; end
                    3'b010: begin ulacontrol = ULA_SLT; legal = 1'b1; end
                    3'b101: begin
                        // only logical right shift; the arithmetic form stays illegal
                        if (funct7 == F7_BASE) begin
                            ulacontrol = ULA_SRL;
                            legal      = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_ITYPE: begin
                case (funct3)
                    3'b000: legal = 1'b1;
                    3'b110: begin ulacontrol = ULA_OR;  legal = 1'b1; end
                    3'b111: begin ulacontrol = ULA_AND; legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: legal = (funct3 == 3'b000);
            OP_JAL:  legal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the multicycle datapath
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [2:0] ULAControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state_q, state_d;
    logic [2:0] dec_ula;
    logic       dec_legal;
    logic       pcupdate, branch;

    ula_decoder u_ula_decoder (
        .op         (OP),
        .funct3     (Funct3),
        .funct7     (Funct7),
        .ulacontrol (dec_ula),
        .legal      (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (MemReady) state_d = DECODE;
            DECODE: begin
                if (!dec_legal) begin
                    state_d = FETCH;
                end else begin
                    case (OP)
                        OP_LOAD, OP_STORE: state_d = MEMADR;
                        OP_RTYPE:          state_d = EXECR;
                        OP_ITYPE:          state_d = EXECI;
                        OP_BRANCH:         state_d = BEQ;
                        OP_JAL:            state_d = JAL;
                        OP_JALR:           state_d = JALR;
                        default:           state_d = FETCH;
                    endcase
                end
            end
            MEMADR:   state_d = (OP == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (MemReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (MemReady) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            JALR:     state_d = JLINK;
            JLINK:    state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pcupdate   = 1'b0;
        branch     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ULASrcA    = SRCA_PC;
        ULASrcB    = SRCB_RD2;
        ULAControl = ULA_ADD;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = imm_sel(OP);
        Illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                ULASrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                pcupdate  = MemReady;
            end
            DECODE: begin
                ULASrcA = SRCA_OLDPC;
                ULASrcB = SRCB_IMM;
                Illegal = !dec_legal;
            end
            MEMADR: begin
                ULASrcA = SRCA_RD1;
                ULASrcB = SRCB_IMM;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ULASrcA    = SRCA_RD1;
                ULAControl = dec_ula;
            end
            EXECI: begin
                ULASrcA    = SRCA_RD1;
                ULASrcB    = SRCB_IMM;
                ULAControl = dec_ula;
            end
            ALUWB:    RegWrite = 1'b1;
            BEQ: begin
                ULASrcA    = SRCA_RD1;
                ULAControl = ULA_SUB;
                branch     = 1'b1;
            end
            JAL: begin
                pcupdate = 1'b1;
                ULASrcA  = SRCA_OLDPC;
                ULASrcB  = SRCB_FOUR;
            end
            JALR: begin
                ULASrcA   = SRCA_RD1;
                ULASrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pcupdate  = 1'b1;
            end
            JLINK: begin
                ULASrcA = SRCA_OLDPC;
                ULASrcB = SRCB_FOUR;
            end
            default: ;
        endcase
        // reset must silence everything at once, even in FETCH where outputs are otherwise live
        if (reset) begin
            pcupdate   = 1'b0;
            branch     = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            ULASrcA    = 2'b00;
            ULASrcB    = 2'b00;
            ULAControl = 3'b000;
            ResultSrc  = 2'b00;
            ImmSrc     = 2'b00;
            Illegal    = 1'b0;
        end
    end

    assign PCWrite = pcupdate | (branch & Zero);
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] OP;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ULASrcA, ULASrcB, ResultSrc, ImmSrc;
    logic [2:0] ULAControl;
    logic       Illegal;
    logic [3:0] State;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .OP         (OP),
        .Funct3     (Funct3),
        .Funct7     (Funct7),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ULASrcA    (ULASrcA),
        .ULASrcB    (ULASrcB),
        .ULAControl (ULAControl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .Illegal    (Illegal),
        .State      (State)
    );

    typedef struct {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic            zero;
        logic            ill;
        logic [2:0]      ula;
        int              len;
        logic [4:0][3:0] seq;
    } vec_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic       cur_ill;
    logic [2:0] cur_ula;

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,SrcA,SrcB,ULAControl,ResultSrc,ImmSrc,Illegal}
    function automatic logic [16:0] model(input logic [3:0] s, input logic mr, input logic z,
                                          input logic ill, input logic [2:0] ula, input logic [6:0] op);
        logic       pcw, irw, rw, mw, adr, il;
        logic [1:0] sa, sbs, rs;
        logic [2:0] uc;
        pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; il = 0;
        sa = 2'b00; sbs = 2'b00; rs = 2'b00; uc = 3'b000;
        case (s)
            4'd0:  begin irw = mr; pcw = mr; sbs = 2'b10; rs = 2'b10; end
            4'd1:  begin sa = 2'b01; sbs = 2'b01; il = ill; end
            4'd2:  begin sa = 2'b10; sbs = 2'b01; end
            4'd3:  adr = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; uc = ula; end
            4'd7:  begin sa = 2'b10; sbs = 2'b01; uc = ula; end
            4'd8:  rw = 1;
            4'd9:  begin sa = 2'b10; uc = 3'b001; pcw = z; end
            4'd10: begin pcw = 1; sa = 2'b01; sbs = 2'b10; end
            4'd11: begin sa = 2'b10; sbs = 2'b01; rs = 2'b10; pcw = 1; end
            4'd12: begin sa = 2'b01; sbs = 2'b10; end
            default: ;
        endcase
        return {pcw, irw, rw, mw, adr, sa, sbs, uc, rs, imm_of(op), il};
    endfunction

    function automatic logic [16:0] dut_outs();
        return {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ULASrcA, ULASrcB,
                ULAControl, ResultSrc, ImmSrc, Illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // entered and left on a falling edge; inputs driven here, outputs sampled 1ns later
    task automatic cycle(input logic [3:0] est, input logic mr);
        exp_t e;
        MemReady = mr;
        sb.push_back(exp_t'({est, model(est, mr, Zero, cur_ill, cur_ula, OP)}));
        #1;
        e = sb.pop_front();
        check("state", 32'(State), 32'(e.st));
        check("outputs", 32'(dut_outs()), 32'(e.outs));
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic zero, input logic ill, input logic [2:0] ula, input int len,
                           input state_t s0, input state_t s1, input state_t s2,
                           input state_t s3, input state_t s4);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.zero = zero; v.ill = ill; v.ula = ula; v.len = len;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        vecs.push_back(v);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic ill, input logic [2:0] ula);
        OP = op; Funct3 = f3; Funct7 = f7; Zero = z; cur_ill = ill; cur_ula = ula;
    endtask

    initial begin
        add_vec(7'b0110011, 3'b000, 7'b0000000, 0, 0, 3'b000, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b000, 7'b0100000, 0, 0, 3'b001, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b111, 7'b0000000, 0, 0, 3'b010, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b110, 7'b0000000, 0, 0, 3'b011, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b100, 7'b0000000, 0, 0, 3'b100, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b010, 7'b0000000, 0, 0, 3'b101, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b101, 7'b0000000, 0, 0, 3'b110, 4, FETCH, DECODE, EXECR, ALUWB, FETCH);
        add_vec(7'b0110011, 3'b101, 7'b0100000, 0, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);
        add_vec(7'b0110011, 3'b001, 7'b0000000, 0, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);
        add_vec(7'b0110011, 3'b000, 7'b0000001, 0, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);
        add_vec(7'b0010011, 3'b000, 7'b0100000, 0, 0, 3'b000, 4, FETCH, DECODE, EXECI, ALUWB, FETCH);
        add_vec(7'b0010011, 3'b110, 7'b0000000, 0, 0, 3'b011, 4, FETCH, DECODE, EXECI, ALUWB, FETCH);
        add_vec(7'b0010011, 3'b111, 7'b0000000, 0, 0, 3'b010, 4, FETCH, DECODE, EXECI, ALUWB, FETCH);
        add_vec(7'b0010011, 3'b100, 7'b0000000, 0, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);
        add_vec(7'b0000011, 3'b000, 7'b0000000, 0, 0, 3'b000, 5, FETCH, DECODE, MEMADR, MEMREAD, MEMWB);
        add_vec(7'b0100011, 3'b000, 7'b0000000, 0, 0, 3'b000, 4, FETCH, DECODE, MEMADR, MEMWRITE, FETCH);
        add_vec(7'b0000011, 3'b010, 7'b0000000, 0, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);
        add_vec(7'b1100011, 3'b000, 7'b0000000, 1, 0, 3'b000, 3, FETCH, DECODE, BEQ, FETCH, FETCH);
        add_vec(7'b1100011, 3'b000, 7'b0000000, 0, 0, 3'b000, 3, FETCH, DECODE, BEQ, FETCH, FETCH);
        add_vec(7'b1100011, 3'b001, 7'b0000000, 1, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);
        add_vec(7'b1101111, 3'b101, 7'b0000000, 0, 0, 3'b000, 4, FETCH, DECODE, JAL, ALUWB, FETCH);
        add_vec(7'b1100111, 3'b000, 7'b0000000, 0, 0, 3'b000, 5, FETCH, DECODE, JALR, JLINK, ALUWB);
        add_vec(7'b1111111, 3'b000, 7'b0000000, 0, 1, 3'b000, 2, FETCH, DECODE, FETCH, FETCH, FETCH);

        // reset holds everything low even with live inputs
        reset = 1'b1;
        MemReady = 1'b1;
        set_instr(7'b0100011, 3'b000, 7'b0000000, 1, 0, 3'b000);
        #3;
        check("reset_state", 32'(State), 32'd0);
        check("reset_outputs", 32'(dut_outs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].ill, vecs[i].ula);
            for (int c = 0; c < vecs[i].len; c++) cycle(vecs[i].seq[c], 1'b1);
        end

        // lw with instruction-fetch and data wait states
        set_instr(7'b0000011, 3'b000, 7'b0000000, 0, 0, 3'b000);
        cycle(FETCH, 1'b0);
        cycle(FETCH, 1'b1);
        cycle(DECODE, 1'b1);
        cycle(MEMADR, 1'b1);
        for (int c = 0; c < 3; c++) cycle(MEMREAD, 1'b0);
        cycle(MEMREAD, 1'b1);
        cycle(MEMWB, 1'b1);

        // sw stalled in MEMWRITE, then reset lands mid-cycle
        set_instr(7'b0100011, 3'b000, 7'b0000000, 0, 0, 3'b000);
        cycle(FETCH, 1'b1);
        cycle(DECODE, 1'b1);
        cycle(MEMADR, 1'b1);
        cycle(MEMWRITE, 1'b0);
        MemReady = 1'b0;
        #1;
        check("memwrite_before_reset", 32'(MemWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("memwrite_async_drop", 32'(MemWrite), 32'd0);
        check("state_async_fetch", 32'(State), 32'd0);
        check("outputs_in_reset", 32'(dut_outs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        set_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 3'b000);
        cycle(FETCH, 1'b1);
        cycle(DECODE, 1'b1);
        cycle(EXECR, 1'b1);
        cycle(ALUWB, 1'b1);
        cycle(FETCH, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all other inputs are synchronous to clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 OP  in  7; Funct3  in  3; Funct7  in  7: fields of the instruction register.
REQ-005 Zero  in  1  ULA zero flag; MemReady  in  1  memory access done this cycle.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each: PC enable, IR enable, register-file write, memory write, address mux (0=PC, 1=Result).
REQ-007 ULASrcA  out  2 (00 PC, 01 OldPC, 10 RD1); ULASrcB  out  2 (00 RD2, 01 ImmExt, 10 constant 4).
REQ-008 ULAControl  out  3 (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 srl).
REQ-009 ResultSrc  out  2 (00 ALUOut, 01 Data, 10 ALUResult); ImmSrc  out  2 (00 I, 01 S, 10 B, 11 J).
REQ-010 Illegal  out  1  one-cycle pulse for an unsupported instruction; State  out  4  current state, for debug.

Function
REQ-011 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR, JLINK.
REQ-012 All outputs not listed for a state SHALL be 0; PCWrite = PCUpdate | (Branch & Zero).
REQ-013 FETCH: AdrSrc=0, SrcA=00, SrcB=10, add, ResultSrc=10; IRWrite=PCUpdate=MemReady; stay until MemReady=1, then DECODE.
REQ-014 DECODE: SrcA=01, SrcB=01, add (branch/JAL target into ALUOut); next state by OP per REQ-015.
REQ-015 Decode: 0000011/0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 with Funct3=000 to BEQ; 1101111 to JAL; 1100111 with Funct3=000 to JALR; any other value to FETCH with Illegal=1.
REQ-016 EXECR SHALL decode Funct3/Funct7: 000/0000000 add, 000/0100000 sub, 111 and, 110 or, 100 xor, 010 slt, 101/0000000 srl; any other combination is illegal (Illegal pulses in DECODE).
REQ-017 EXECI SHALL decode Funct3: 000 add, 110 or, 111 and; any other value is illegal.
REQ-018 MEMADR: SrcA=10, SrcB=01, add; next MEMREAD when OP=0000011, else MEMWRITE; loads and stores require Funct3=000, otherwise illegal.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady, then MEMWB; MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-020 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until the MemReady cycle inclusive, then FETCH.
REQ-021 EXECR/EXECI: SrcA=10, SrcB=00/01, ULAControl per decode, then ALUWB; ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-022 BEQ: SrcA=10, SrcB=00, sub, ResultSrc=00, Branch=1, then FETCH; the PC is taken only when Zero=1 in that cycle.
REQ-023 JAL: ResultSrc=00, PCUpdate=1, SrcA=01, SrcB=10, add (link value), then ALUWB.
REQ-024 JALR: SrcA=10, SrcB=01, add, ResultSrc=10, PCUpdate=1, then JLINK; JLINK: SrcA=01, SrcB=10, add, then ALUWB.
REQ-025 ImmSrc SHALL be a combinational function of OP in every state: 0100011 gives S, 1100011 gives B, 1101111 gives J, otherwise I.
REQ-026 Latency SHALL be: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4, jalr 5, with zero-wait memory.

Reset
REQ-027 Asserting reset SHALL immediately force FETCH with every output 0, including mid-MEMWRITE, where MemWrite drops asynchronously.
REQ-028 The first cycle after reset deassertion SHALL be FETCH.

Structure
REQ-029 A shared package SHALL hold the state enum and the ULAControl, ULASrcA/B, ResultSrc and ImmSrc codes, for reuse by the datapath.
REQ-030 The Funct3/Funct7 to ULAControl and legality decode SHALL be a combinational sub-module ula_decoder; the FSM stays in multicycle_control.

Verification
REQ-031 add (OP=0110011, F3=000, F7=0000000), MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ULAControl=000 in EXECR.
REQ-032 lw with MemReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, AdrSrc=1 throughout; MEMWB asserts RegWrite=1 with ResultSrc=01.
REQ-033 beq with Zero=1, then with Zero=0 -> PCWrite=1 in BEQ, then PCWrite=0 in BEQ; FETCH follows in both cases.
REQ-034 OP=1111111 -> Illegal=1 for exactly one cycle in DECODE, then FETCH; no RegWrite or MemWrite pulse.
REQ-035 sw with MemReady=0, then reset asserted mid-MEMWRITE -> MemWrite=0 and State=FETCH asynchronously; normal fetch resumes after release.
REQ-036 jalr -> JALR asserts PCWrite with ResultSrc=10; JLINK, then ALUWB writes OldPC+4; 5 cycles total.
